msi_cache_array: RTL and testbench
==================================

# msi_cache_array

Parametrised direct-mapped private cache of LINES entries, each holding an MSI coherence state, an address tag and one data word. It accepts processor read/write requests through a valid/ready handshake and resolves misses over a shared snooping bus with BusRd, BusRdX and WriteBack messages. It also snoops other caches' bus traffic every cycle, downgrading or invalidating its lines and flushing dirty data. It sits between one processor port and the multi-cache coherence bus.

## Interface
Parameters:
- LINES, 4: number of lines; power of two, ≥2; IDX_W = log2(LINES).
- ADDR_W, 5: address width; tag = addr[ADDR_W-1:IDX_W], index = addr[IDX_W-1:0].
- DATA_W, 4: data word width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears everything below.
- cpu_req_valid / cpu_req_ready  in / out  1  processor request handshake.
- cpu_req_write  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W;  cpu_req_data  in  DATA_W.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_hit  out  1  1 = serviced without bus traffic.
- cpu_resp_data  out  DATA_W  line data after the access.
- bus_req_valid  out  1;  bus_req_ready  in  1  bus grant.
- bus_req_op  out  2  01 BusRd, 10 BusRdX, 11 WriteBack.
- bus_req_addr  out  ADDR_W;  bus_req_data  out  DATA_W  (WriteBack payload).
- bus_fill_valid  in  1;  bus_fill_data  in  DATA_W  miss fill.
- snoop_valid  in  1;  snoop_op  in  2  (same encoding);  snoop_addr  in  ADDR_W.
- snoop_flush_valid  out  1;  snoop_flush_data  out  DATA_W.

## Operation
- Line states: I = 00, S = 01, M = 10. Hit = state ≠ I and tag match.
- Controller FSM: IDLE, COMPARE, WRITEBACK, REQUEST, WAIT_FILL.
- IDLE: cpu_req_ready = 1; on valid&ready latch write/addr/data → COMPARE.
- COMPARE: read hit (S/M), or write hit in M (data overwritten) → pulse response with hit = 1 → IDLE. Otherwise (miss, or write to S line): victim in M with another tag → WRITEBACK, else → REQUEST.
- WRITEBACK: bus_req_valid = 1, op 11, addr = {victim tag, index}, data = victim data; on bus_req_ready the line becomes I → REQUEST.
- REQUEST: bus_req_valid = 1, op 01 (read) or 10 (write), addr = request addr; on bus_req_ready → WAIT_FILL.
- WAIT_FILL: on bus_fill_valid install tag; read → S, data = fill; write → M, data = cpu data (fill discarded). Response pulse with hit = 0 → IDLE.
- Snooping, every cycle and independent of the FSM, on a hit line: BusRd on M → flush, go S; BusRdX on S → I; BusRdX on M → flush, go I; BusRd on S and WriteBack → no change. Misses ignored.
- Priority: in COMPARE, a snoop hitting the same index takes effect and the controller stays in COMPARE one more cycle, re-evaluating. A snoop and a fill install to the same index in one cycle: install wins, snoop dropped.
- bus_fill_valid outside WAIT_FILL, and bus_req_ready outside WRITEBACK/REQUEST, are ignored.

## Timing
- Reset values: all lines I, tag 0, data 0; FSM IDLE; cpu_req_ready = 1; every other output 0. Reset mid-operation aborts immediately (bus_req_valid drops asynchronously) with no writeback.
- Handshake at edge T → COMPARE in cycle T+1 → hit response registered, valid in cycle T+2; cpu_req_ready high again in T+2.
- bus_req_valid/op/addr/data stay stable from assertion until the granting edge; deassert the cycle after.
- Miss response: the cycle after the edge sampling bus_fill_valid.
- Snoop sampled at edge S → line update and flush pulse (with old data) in cycle S+1, one cycle wide.
- All outputs registered.

## Structure
- Package msi_pkg: line-state encodings (I/S/M), bus op encodings, controller FSM enum.
- One sub-module, msi_line: a single line register (state, tag, data) with write enable and asynchronous reset to I/0/0; instantiated LINES times via generate. Controller, snoop logic and muxing in msi_cache_array.

## Test plan
(defaults; addr 06 = index 2, tag 1; addr 0E = index 2, tag 3)
- Reset, read 06 → BusRd addr 06; grant; fill A → resp hit=0 data A; line 2 = S.
- Read 06 again → resp valid at T+2, hit=1, data A, no bus_req_valid.
- Write 06 data 3 → BusRdX addr 06; fill F → resp hit=0 data 3; line 2 = M, data 3.
- Snoop BusRd 06 → next cycle snoop_flush_valid = 1, data 3; line 2 = S. Then snoop BusRdX 06 → line I, no flush.
- Line 2 = M/tag 1/data 3; read 0E → WriteBack addr 06 data 3, then BusRd 0E; fill 7 → resp data 7, line S/tag 3.
- Assert reset in WAIT_FILL → bus_req_valid 0 and cpu_req_ready 1 at once; after release read 06 misses (BusRd issued).

Source files
------------

// File: rtl/msi_pkg.sv
// Shared encodings for the MSI private cache: line states, bus ops, controller states.
package msi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10
  } line_state_t;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_BUSRD  = 2'b01;
  localparam logic [1:0] OP_BUSRDX = 2'b10;
  localparam logic [1:0] OP_WB     = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    REQUEST   = 3'd3,
    WAIT_FILL = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/msi_line.sv
// One cache line register: coherence state, tag and data word, reset to I/0/0.
module msi_line
  import msi_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  line_state_t       next_state,
  input  logic [TAG_W-1:0]  next_tag,
  input  logic [DATA_W-1:0] next_data,
  output line_state_t       state,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_I;
      tag   <= '0;
      data  <= '0;
    end else if (we) begin
      state <= next_state;
      tag   <= next_tag;
      data  <= next_data;
    end
  end

endmodule

// File: rtl/msi_cache_array.sv
// Direct-mapped MSI private cache: processor request controller plus always-on bus snooper.
//   state     | meaning
//   IDLE      | ready for a processor request
//   COMPARE   | tag/state lookup of the latched request
//   WRITEBACK | evicting a dirty victim (WriteBack on the bus)
//   REQUEST   | issuing BusRd / BusRdX for the missing line
//   WAIT_FILL | waiting for the bus fill, then installing the line
module msi_cache_array
  import msi_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_data,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [1:0]        bus_req_op,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_data,
  input  logic              bus_fill_valid,
  input  logic [DATA_W-1:0] bus_fill_data,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush_valid,
  output logic [DATA_W-1:0] snoop_flush_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  line_state_t       line_state [LINES];
  logic [TAG_W-1:0]  line_tag   [LINES];
  logic [DATA_W-1:0] line_data  [LINES];

  ctrl_state_t       state, state_next;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr, vic_addr;
  logic [DATA_W-1:0] req_data, vic_data;

  logic [IDX_W-1:0]  req_idx, snoop_idx;
  logic [TAG_W-1:0]  req_tag, snoop_tag;
  line_state_t       cur_state;
  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] cur_data;
  logic              cur_hit, cpu_hit_ok, snoop_hit, snoop_conflict;

  assign req_idx   = req_addr[IDX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:IDX_W];
  assign snoop_idx = snoop_addr[IDX_W-1:0];
  assign snoop_tag = snoop_addr[ADDR_W-1:IDX_W];
  assign cur_state = line_state[req_idx];
  assign cur_tag   = line_tag[req_idx];
  assign cur_data  = line_data[req_idx];

  assign cur_hit        = (cur_state != ST_I) && (cur_tag == req_tag);
  assign cpu_hit_ok     = cur_hit && (!req_write || cur_state == ST_M);
  assign snoop_hit      = snoop_valid && (line_state[snoop_idx] != ST_I) &&
                          (line_tag[snoop_idx] == snoop_tag);
  // A snoop landing on the line under lookup forces a fresh compare next cycle.
  assign snoop_conflict = snoop_hit && (snoop_idx == req_idx);

  logic              ctrl_we;
  line_state_t       ctrl_st;
  logic [TAG_W-1:0]  ctrl_tag;
  logic [DATA_W-1:0] ctrl_data;

  always_comb begin
    ctrl_we   = 1'b0;
    ctrl_st   = cur_state;
    ctrl_tag  = cur_tag;
    ctrl_data = cur_data;
    case (state)
      COMPARE: if (!snoop_conflict && cpu_hit_ok && req_write) begin
        ctrl_we   = 1'b1;
        ctrl_st   = ST_M;
        ctrl_data = req_data;
      end
      WRITEBACK: if (bus_req_ready) begin
        ctrl_we = 1'b1;
        ctrl_st = ST_I;
      end
      WAIT_FILL: if (bus_fill_valid) begin
        ctrl_we   = 1'b1;
        ctrl_tag  = req_tag;
        ctrl_st   = req_write ? ST_M : ST_S;
        ctrl_data = req_write ? req_data : bus_fill_data;
      end
      default: ;
    endcase
  end

  logic        snoop_we, snoop_flush, snoop_drop;
  line_state_t snoop_st;

  always_comb begin
    snoop_we    = 1'b0;
    snoop_flush = 1'b0;
    snoop_st    = line_state[snoop_idx];
    if (snoop_hit) begin
      if (snoop_op == OP_BUSRD && line_state[snoop_idx] == ST_M) begin
        snoop_we    = 1'b1;
        snoop_flush = 1'b1;
        snoop_st    = ST_S;
      end else if (snoop_op == OP_BUSRDX) begin
        snoop_we    = 1'b1;
        snoop_flush = (line_state[snoop_idx] == ST_M);
        snoop_st    = ST_I;
      end
    end
  end

  // Controller updates to the same line win; the colliding snoop is dropped entirely.
  assign snoop_drop = ctrl_we && (req_idx == snoop_idx);

  for (genvar i = 0; i < LINES; i++) begin : g_line
    logic              we;
    line_state_t       nst;
    logic [TAG_W-1:0]  ntag;
    logic [DATA_W-1:0] ndata;

    always_comb begin
      we    = 1'b0;
      nst   = line_state[i];
      ntag  = line_tag[i];
      ndata = line_data[i];
      if (ctrl_we && req_idx == IDX_W'(i)) begin
        we    = 1'b1;
        nst   = ctrl_st;
        ntag  = ctrl_tag;
        ndata = ctrl_data;
      end else if (snoop_we && snoop_idx == IDX_W'(i)) begin
        we  = 1'b1;
        nst = snoop_st;
      end
    end

    msi_line #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_line (
      .clock(clock), .reset(reset), .we(we),
      .next_state(nst), .next_tag(ntag), .next_data(ndata),
      .state(line_state[i]), .tag(line_tag[i]), .data(line_data[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (cpu_req_valid) state_next = COMPARE;
      COMPARE: begin
        if (snoop_conflict)                               state_next = COMPARE;
        else if (cpu_hit_ok)                              state_next = IDLE;
        else if (cur_state == ST_M && cur_tag != req_tag) state_next = WRITEBACK;
        else                                              state_next = REQUEST;
      end
      WRITEBACK: if (bus_req_ready)  state_next = REQUEST;
      REQUEST:   if (bus_req_ready)  state_next = WAIT_FILL;
      WAIT_FILL: if (bus_fill_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready = (state == IDLE);
    bus_req_valid = (state == WRITEBACK) || (state == REQUEST);
    bus_req_op    = OP_NONE;
    bus_req_addr  = '0;
    bus_req_data  = '0;
    if (state == WRITEBACK) begin
      bus_req_op   = OP_WB;
      bus_req_addr = vic_addr;
      bus_req_data = vic_data;
    end else if (state == REQUEST) begin
      bus_req_op   = req_write ? OP_BUSRDX : OP_BUSRD;
      bus_req_addr = req_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_write         <= 1'b0;
      req_addr          <= '0;
      req_data          <= '0;
      vic_addr          <= '0;
      vic_data          <= '0;
      cpu_resp_valid    <= 1'b0;
      cpu_resp_hit      <= 1'b0;
      cpu_resp_data     <= '0;
      snoop_flush_valid <= 1'b0;
      snoop_flush_data  <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        req_write <= cpu_req_write;
        req_addr  <= cpu_req_addr;
        req_data  <= cpu_req_data;
      end
      if (state == COMPARE) begin
        vic_addr <= {cur_tag, req_idx};
        vic_data <= cur_data;
      end
      cpu_resp_valid <= 1'b0;
      cpu_resp_hit   <= 1'b0;
      cpu_resp_data  <= '0;
      if (state == COMPARE && !snoop_conflict && cpu_hit_ok) begin
        cpu_resp_valid <= 1'b1;
        cpu_resp_hit   <= 1'b1;
        cpu_resp_data  <= req_write ? req_data : cur_data;
      end else if (state == WAIT_FILL && bus_fill_valid) begin
        cpu_resp_valid <= 1'b1;
        cpu_resp_data  <= req_write ? req_data : bus_fill_data;
      end
      snoop_flush_valid <= snoop_flush && !snoop_drop;
      snoop_flush_data  <= (snoop_flush && !snoop_drop) ? line_data[snoop_idx] : '0;
    end
  end

endmodule

// File: tb/tb_msi_cache_array.sv
// Directed bench for msi_cache_array: misses, hits, upgrades, snoops, writeback and reset abort.
module tb_msi_cache_array;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [4:0] cpu_req_addr;
  logic [3:0] cpu_req_data;
  logic       cpu_resp_valid, cpu_resp_hit;
  logic [3:0] cpu_resp_data;
  logic       bus_req_valid, bus_req_ready;
  logic [1:0] bus_req_op;
  logic [4:0] bus_req_addr;
  logic [3:0] bus_req_data;
  logic       bus_fill_valid;
  logic [3:0] bus_fill_data;
  logic       snoop_valid;
  logic [1:0] snoop_op;
  logic [4:0] snoop_addr;
  logic       snoop_flush_valid;
  logic [3:0] snoop_flush_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  msi_cache_array #(.LINES(4), .ADDR_W(5), .DATA_W(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit), .cpu_resp_data(cpu_resp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_op(bus_req_op),
    .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data),
    .bus_fill_valid(bus_fill_valid), .bus_fill_data(bus_fill_data),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_flush_valid(snoop_flush_valid), .snoop_flush_data(snoop_flush_data)
  );

  task automatic cpu_issue(input logic w, input logic [4:0] a, input logic [3:0] d);
    @(negedge clock);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_data  = d;
    @(posedge clock);
    #1 cpu_req_valid = 1'b0;
  endtask

  task automatic wait_bus_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic grant();
    bus_req_ready = 1'b1;
    @(posedge clock);
    #1 bus_req_ready = 1'b0;
  endtask

  task automatic fill(input logic [3:0] d);
    @(negedge clock);
    bus_fill_valid = 1'b1;
    bus_fill_data  = d;
    @(posedge clock);
    #1 bus_fill_valid = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] op, input logic [4:0] a);
    @(negedge clock);
    snoop_valid = 1'b1;
    snoop_op    = op;
    snoop_addr  = a;
    @(posedge clock);
    #1 snoop_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cpu_req_ready); end
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got %b want 0", bus_req_valid); end
    checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", cpu_resp_valid); end
    checks++; if (snoop_flush_valid !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", snoop_flush_valid); end
    checks++; if (dut.line_state[2] !== 2'b00) begin errors++; $display("FAIL reset_line2 got %b want 00", dut.line_state[2]); end
  endtask

  task automatic test_read_miss();
    bit ok;
    cpu_issue(1'b0, 5'h06, 4'h0);
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rdmiss_busreq got timeout want bus_req_valid"); end
    checks++; if (bus_req_op !== 2'b01) begin errors++; $display("FAIL rdmiss_op got %b want 01", bus_req_op); end
    checks++; if (bus_req_addr !== 5'h06) begin errors++; $display("FAIL rdmiss_addr got %h want 06", bus_req_addr); end
    grant();
    fill(4'hA);
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL rdmiss_resp_valid got %b want 1", cpu_resp_valid); end
    checks++; if (cpu_resp_hit !== 1'b0) begin errors++; $display("FAIL rdmiss_hit got %b want 0", cpu_resp_hit); end
    checks++; if (cpu_resp_data !== 4'hA) begin errors++; $display("FAIL rdmiss_data got %h want A", cpu_resp_data); end
    checks++; if (dut.line_state[2] !== 2'b01) begin errors++; $display("FAIL rdmiss_line_state got %b want 01", dut.line_state[2]); end
  endtask

  task automatic test_read_hit();
    cpu_issue(1'b0, 5'h06, 4'h0);
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL rdhit_early_resp got %b want 0", cpu_resp_valid); end
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rdhit_bus got %b want 0", bus_req_valid); end
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL rdhit_resp_valid got %b want 1", cpu_resp_valid); end
    checks++; if (cpu_resp_hit !== 1'b1) begin errors++; $display("FAIL rdhit_hit got %b want 1", cpu_resp_hit); end
    checks++; if (cpu_resp_data !== 4'hA) begin errors++; $display("FAIL rdhit_data got %h want A", cpu_resp_data); end
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rdhit_ready got %b want 1", cpu_req_ready); end
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rdhit_bus_late got %b want 0", bus_req_valid); end
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL rdhit_pulse_width got %b want 0", cpu_resp_valid); end
  endtask

  task automatic test_write_upgrade();
    bit ok;
    cpu_issue(1'b1, 5'h06, 4'h3);
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL upg_busreq got timeout want bus_req_valid"); end
    checks++; if (bus_req_op !== 2'b10) begin errors++; $display("FAIL upg_op got %b want 10", bus_req_op); end
    checks++; if (bus_req_addr !== 5'h06) begin errors++; $display("FAIL upg_addr got %h want 06", bus_req_addr); end
    grant();
    fill(4'hF);
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL upg_resp_valid got %b want 1", cpu_resp_valid); end
    checks++; if (cpu_resp_hit !== 1'b0) begin errors++; $display("FAIL upg_hit got %b want 0", cpu_resp_hit); end
    checks++; if (cpu_resp_data !== 4'h3) begin errors++; $display("FAIL upg_data got %h want 3", cpu_resp_data); end
    checks++; if (dut.line_state[2] !== 2'b10) begin errors++; $display("FAIL upg_line_state got %b want 10", dut.line_state[2]); end
    checks++; if (dut.line_data[2] !== 4'h3) begin errors++; $display("FAIL upg_line_data got %h want 3", dut.line_data[2]); end
  endtask

  task automatic test_snoop();
    snoop(2'b01, 5'h06);
    @(negedge clock);
    checks++; if (snoop_flush_valid !== 1'b1) begin errors++; $display("FAIL snp_rd_flush got %b want 1", snoop_flush_valid); end
    checks++; if (snoop_flush_data !== 4'h3) begin errors++; $display("FAIL snp_rd_data got %h want 3", snoop_flush_data); end
    checks++; if (dut.line_state[2] !== 2'b01) begin errors++; $display("FAIL snp_rd_state got %b want 01", dut.line_state[2]); end
    @(negedge clock);
    checks++; if (snoop_flush_valid !== 1'b0) begin errors++; $display("FAIL snp_flush_width got %b want 0", snoop_flush_valid); end
    snoop(2'b01, 5'h0E);
    @(negedge clock);
    checks++; if (dut.line_state[2] !== 2'b01) begin errors++; $display("FAIL snp_tag_miss got %b want 01", dut.line_state[2]); end
    snoop(2'b10, 5'h06);
    @(negedge clock);
    checks++; if (snoop_flush_valid !== 1'b0) begin errors++; $display("FAIL snp_rdx_flush got %b want 0", snoop_flush_valid); end
    checks++; if (dut.line_state[2] !== 2'b00) begin errors++; $display("FAIL snp_rdx_state got %b want 00", dut.line_state[2]); end
  endtask

  task automatic test_writeback();
    bit ok;
    cpu_issue(1'b1, 5'h06, 4'h3);
    wait_bus_req(ok);
    grant();
    fill(4'h9);
    @(negedge clock);
    checks++; if (dut.line_state[2] !== 2'b10) begin errors++; $display("FAIL wb_setup_state got %b want 10", dut.line_state[2]); end
    cpu_issue(1'b0, 5'h0E, 4'h0);
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wb_busreq got timeout want bus_req_valid"); end
    checks++; if (bus_req_op !== 2'b11) begin errors++; $display("FAIL wb_op got %b want 11", bus_req_op); end
    checks++; if (bus_req_addr !== 5'h06) begin errors++; $display("FAIL wb_addr got %h want 06", bus_req_addr); end
    checks++; if (bus_req_data !== 4'h3) begin errors++; $display("FAIL wb_data got %h want 3", bus_req_data); end
    repeat (2) @(negedge clock);
    checks++; if (bus_req_valid !== 1'b1 || bus_req_op !== 2'b11 || bus_req_addr !== 5'h06)
      begin errors++; $display("FAIL wb_stable got v=%b op=%b a=%h want 1/11/06", bus_req_valid, bus_req_op, bus_req_addr); end
    grant();
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wb_rd_busreq got timeout want bus_req_valid"); end
    checks++; if (bus_req_op !== 2'b01) begin errors++; $display("FAIL wb_rd_op got %b want 01", bus_req_op); end
    checks++; if (bus_req_addr !== 5'h0E) begin errors++; $display("FAIL wb_rd_addr got %h want 0E", bus_req_addr); end
    checks++; if (dut.line_state[2] !== 2'b00) begin errors++; $display("FAIL wb_victim_inv got %b want 00", dut.line_state[2]); end
    grant();
    fill(4'h7);
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL wb_resp_valid got %b want 1", cpu_resp_valid); end
    checks++; if (cpu_resp_data !== 4'h7) begin errors++; $display("FAIL wb_resp_data got %h want 7", cpu_resp_data); end
    checks++; if (dut.line_state[2] !== 2'b01) begin errors++; $display("FAIL wb_new_state got %b want 01", dut.line_state[2]); end
    checks++; if (dut.line_tag[2] !== 3'd3) begin errors++; $display("FAIL wb_new_tag got %h want 3", dut.line_tag[2]); end
  endtask

  task automatic test_stray_inputs();
    @(negedge clock);
    bus_fill_valid = 1'b1;
    bus_fill_data  = 4'h5;
    bus_req_ready  = 1'b1;
    @(posedge clock);
    #1 bus_fill_valid = 1'b0;
    bus_req_ready = 1'b0;
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL stray_resp got %b want 0", cpu_resp_valid); end
    checks++; if (dut.line_data[2] !== 4'h7) begin errors++; $display("FAIL stray_line_data got %h want 7", dut.line_data[2]); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    cpu_issue(1'b0, 5'h06, 4'h0);
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_busreq got timeout want bus_req_valid"); end
    grant();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_async_bus got %b want 0", bus_req_valid); end
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got %b want 1", cpu_req_ready); end
    @(negedge clock);
    reset = 1'b0;
    checks++; if (dut.line_state[2] !== 2'b00) begin errors++; $display("FAIL rst_line_cleared got %b want 00", dut.line_state[2]); end
    cpu_issue(1'b0, 5'h06, 4'h0);
    wait_bus_req(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_reread_busreq got timeout want bus_req_valid"); end
    checks++; if (bus_req_op !== 2'b01 || bus_req_addr !== 5'h06)
      begin errors++; $display("FAIL rst_reread_req got op=%b a=%h want 01/06", bus_req_op, bus_req_addr); end
    grant();
    fill(4'h5);
    @(negedge clock);
    checks++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== 4'h5)
      begin errors++; $display("FAIL rst_reread_resp got v=%b d=%h want 1/5", cpu_resp_valid, cpu_resp_data); end
  endtask

  initial begin
    reset          = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_write  = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_data   = '0;
    bus_req_ready  = 1'b0;
    bus_fill_valid = 1'b0;
    bus_fill_data  = '0;
    snoop_valid    = 1'b0;
    snoop_op       = '0;
    snoop_addr     = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_upgrade();
    test_snoop();
    test_writeback();
    test_stray_inputs();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
